// File: rtl/spi_flash_responder.sv
// Mode-0 SPI target emulating a read-only serial flash (READ, FAST_READ, JEDEC_ID, RDSR) backed by an OBI-style read master.
// Define SPI_FLASH_RESPONDER_STATS_EN to build the completed-read counter on rd_count_o.
module spi_flash_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [23:0] JEDEC_ID  = 24'hEF6018
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sck_i,
  input  logic        spi_csb_i,
  input  logic        spi_sd_i,
  output logic        spi_sd_o,
  output logic        spi_sd_en_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        underrun_o,
  output logic [15:0] rd_count_o
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FAST  = 8'h0B;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned WADDR_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  logic [1:0] sck_sync, csb_sync, sd_sync;
  logic       sck_q, csb_q;
  logic       sck_s, csb_s, sd_s;
  logic       sck_rise, sck_fall, csb_fall;

  state_t state, state_next;

  logic [4:0]         bit_cnt;
  logic [2:0]         tx_cnt;
  logic [ADDR_W-1:0]  rx_shift, rx_next;
  logic [7:0]         cmd;
  logic [ADDR_W-1:0]  rd_addr, rd_addr_inc;
  logic [1:0]         jedec_idx;
  logic [7:0]         tx_shift, tx_byte;

  logic [31:0]        word_data;
  logic               word_valid;
  logic               mem_wait, discard, fetch_due;
  logic [WADDR_W-1:0] fetch_waddr, fetch_waddr_c;

  logic capture_c, count_bit_c, bit_last_c, cmd_done_c, addr_done_c;
  logic load_c, shift_c, en_c;
  logic is_read, read_load, lane_last, fetch_c, busy, rsp;

  // Two-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync <= 2'b00;
      csb_sync <= 2'b11;
      sd_sync  <= 2'b00;
      sck_q    <= 1'b0;
      csb_q    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], spi_sck_i};
      csb_sync <= {csb_sync[0], spi_csb_i};
      sd_sync  <= {sd_sync[0], spi_sd_i};
      sck_q    <= sck_sync[1];
      csb_q    <= csb_sync[1];
    end
  end

  assign sck_s    = sck_sync[1];
  assign csb_s    = csb_sync[1];
  assign sd_s     = sd_sync[1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csb_fall = ~csb_s & csb_q;
  assign rx_next  = {rx_shift[ADDR_W-2:0], sd_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (csb_s) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_CMD;
        S_CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            case (rx_next[7:0])
              CMD_READ, CMD_FAST:  state_next = S_ADDR;
              CMD_JEDEC, CMD_RDSR: state_next = S_DATA;
              default:             state_next = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (sck_rise && bit_cnt == 5'd23)
            state_next = (cmd == CMD_FAST) ? S_DUMMY : S_DATA;
        end
        S_DUMMY: begin
          if (sck_rise && bit_cnt == 5'd7) state_next = S_DATA;
        end
        default: state_next = state;
      endcase
    end
  end

  // Per-state strobes; everything is quiet once chip select is seen high
  always_comb begin
    capture_c   = 1'b0;
    count_bit_c = 1'b0;
    bit_last_c  = 1'b0;
    cmd_done_c  = 1'b0;
    addr_done_c = 1'b0;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    en_c        = 1'b0;
    if (!csb_s) begin
      case (state)
        S_CMD: begin
          capture_c   = sck_rise;
          count_bit_c = sck_rise;
          bit_last_c  = (bit_cnt == 5'd7);
          cmd_done_c  = sck_rise && (bit_cnt == 5'd7);
        end
        S_ADDR: begin
          capture_c   = sck_rise;
          count_bit_c = sck_rise;
          bit_last_c  = (bit_cnt == 5'd23);
          addr_done_c = sck_rise && (bit_cnt == 5'd23);
        end
        S_DUMMY: begin
          count_bit_c = sck_rise;
          bit_last_c  = (bit_cnt == 5'd7);
        end
        S_DATA: begin
          en_c    = 1'b1;
          load_c  = sck_fall && (tx_cnt == 3'd0);
          shift_c = sck_fall && (tx_cnt != 3'd0);
        end
        default: ;
      endcase
    end
  end

  assign is_read       = (cmd == CMD_READ) || (cmd == CMD_FAST);
  assign read_load     = load_c && is_read;
  assign lane_last     = (rd_addr[1:0] == 2'b11);
  assign rd_addr_inc   = rd_addr + 24'd1;
  assign fetch_c       = addr_done_c || (read_load && lane_last);
  assign fetch_waddr_c = addr_done_c ? rx_next[ADDR_W-1:2] : rd_addr_inc[ADDR_W-1:2];
  assign busy          = mem_req_o | mem_wait;
  assign rsp           = mem_wait & mem_rvalid_i;

  // Byte presented at the next load; an unfilled word reads as 0xFF
  always_comb begin
    tx_byte = 8'h00;
    if (is_read) begin
      if (!word_valid) begin
        tx_byte = 8'hFF;
      end else begin
        case (rd_addr[1:0])
          2'd0:    tx_byte = word_data[7:0];
          2'd1:    tx_byte = word_data[15:8];
          2'd2:    tx_byte = word_data[23:16];
          default: tx_byte = word_data[31:24];
        endcase
      end
    end else if (cmd == CMD_JEDEC) begin
      case (jedec_idx)
        2'd0:    tx_byte = JEDEC_ID[23:16];
        2'd1:    tx_byte = JEDEC_ID[15:8];
        2'd2:    tx_byte = JEDEC_ID[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= 5'd0;
      tx_cnt      <= 3'd0;
      rx_shift    <= '0;
      cmd         <= 8'h00;
      rd_addr     <= '0;
      jedec_idx   <= 2'd0;
      tx_shift    <= 8'h00;
      spi_sd_o    <= 1'b0;
      spi_sd_en_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      spi_sd_en_o <= en_c;
      if (csb_fall) underrun_o <= 1'b0;
      if (csb_s) begin
        bit_cnt   <= 5'd0;
        tx_cnt    <= 3'd0;
        jedec_idx <= 2'd0;
        spi_sd_o  <= 1'b0;
      end else begin
        if (capture_c)   rx_shift <= rx_next;
        if (count_bit_c) bit_cnt  <= bit_last_c ? 5'd0 : bit_cnt + 5'd1;
        if (cmd_done_c)  cmd      <= rx_next[7:0];
        if (addr_done_c) rd_addr  <= rx_next;
        if (en_c && sck_fall) tx_cnt <= tx_cnt + 3'd1;
        if (load_c) begin
          tx_shift <= tx_byte;
          spi_sd_o <= tx_byte[7];
          if (cmd == CMD_JEDEC && jedec_idx != 2'd3) jedec_idx <= jedec_idx + 2'd1;
        end else if (shift_c) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          spi_sd_o <= tx_shift[6];
        end
        if (read_load) begin
          rd_addr <= rd_addr_inc;
          if (!word_valid) underrun_o <= 1'b1;
        end
      end
    end
  end

  // Single-outstanding read master; responses owed to an abandoned word are dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wait    <= 1'b0;
      discard     <= 1'b0;
      fetch_due   <= 1'b0;
      fetch_waddr <= '0;
      word_data   <= 32'h0;
      word_valid  <= 1'b0;
    end else begin
      if (mem_req_o && mem_gnt_i) begin
        mem_req_o <= 1'b0;
        mem_wait  <= 1'b1;
      end
      if (rsp) begin
        mem_wait <= 1'b0;
        if (discard) begin
          discard <= 1'b0;
        end else begin
          word_data  <= mem_rdata_i;
          word_valid <= 1'b1;
        end
      end
      if (csb_s) begin
        fetch_due  <= 1'b0;
        word_valid <= 1'b0;
        if (busy && !rsp) discard <= 1'b1;
      end else begin
        if ((fetch_c || fetch_due) && !busy) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= BASE_ADDR + {8'h00, (fetch_c ? fetch_waddr_c : fetch_waddr), 2'b00};
          fetch_due  <= 1'b0;
        end else if (fetch_c) begin
          fetch_due   <= 1'b1;
          fetch_waddr <= fetch_waddr_c;
        end
        if (addr_done_c || (read_load && lane_last)) word_valid <= 1'b0;
        if (read_load && lane_last && !word_valid && busy && !rsp) discard <= 1'b1;
      end
    end
  end

`ifdef SPI_FLASH_RESPONDER_STATS_EN
  logic csb_rise, got_byte, byte_done;

  assign csb_rise  = csb_s & ~csb_q;
  // A data byte counts once its eighth bit has been clocked by the host
  assign byte_done = en_c & sck_rise & (tx_cnt == 3'd0) & is_read;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      got_byte   <= 1'b0;
      rd_count_o <= 16'h0000;
    end else begin
      if (csb_rise && got_byte && rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
      if (csb_s)          got_byte <= 1'b0;
      else if (byte_done) got_byte <= 1'b1;
    end
  end
`else
  assign rd_count_o = 16'h0000;
`endif

endmodule
